mult_arbiter: RTL
=================

Name: mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one `multiplier` instance (WIDTH-bit operands, 2*WIDTH-bit product) between NREQ independent requesters.
- Latches the winning requester's operands and drives the multiplier's req/rdy/done handshake.
- Returns the product to the winner with a one-cycle done pulse.
- Sits between requesting agents and the multiplier in the toy datapath top level.

Parameters:
- WIDTH, 5, operand width; product width is 2*WIDTH.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, watchdog limit in cycles (used only with MULT_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_vec  in  NREQ  per-requester request level; bit i belongs to requester i.
- a_vec  in  NREQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH].
- b_vec  in  NREQ*WIDTH  packed operand B; same packing as a_vec.
- gnt_vec  out  NREQ  one-hot, one-cycle pulse: operands of requester i captured.
- done_vec  out  NREQ  one-hot, one-cycle pulse: result for requester i valid on ab_out.
- ab_out  out  2*WIDTH  product returned to requester; valid only while done_vec != 0.
- err_out  out  1  timeout flag, qualified by done_vec.
- busy  out  1  high whenever the FSM is not IDLE.
- m_req  out  1  request to multiplier.
- m_rdy  in  1  multiplier idle / able to accept.
- m_a  out  WIDTH  operand A to multiplier.
- m_b  out  WIDTH  operand B to multiplier.
- m_done  in  1  multiplier one-cycle completion pulse.
- m_ab  in  2*WIDTH  multiplier product, valid with m_done.

Behaviour:
- Reset (rst=1 at a rising edge) values:
  - FSM = IDLE.
  - gnt_vec, done_vec, ab_out, err_out, busy, m_req, m_a, m_b all = 0.
  - RR pointer = 0.
- Reset mid-transaction abandons it: no done pulse, no grant. The multiplier is reset from the same source.
- Multiplier handshake: a transfer occurs on a rising edge where m_req=1 and m_rdy=1. m_done pulses for exactly one cycle with m_ab valid.
- States: IDLE, ISSUE, BUSY.
- IDLE:
  - When req_vec != 0 and m_rdy=1 in cycle N, select a winner W by round-robin: first set bit at or above the pointer, wrapping modulo NREQ.
  - At that edge: register W; m_a/m_b <= operands of W; gnt_vec[W] = 1 during cycle N+1; move to ISSUE.
  - When req_vec = 0 or m_rdy = 0: stay in IDLE, no grant.
- ISSUE:
  - m_req = 1, m_a/m_b held.
  - On an edge with m_rdy = 1: go to BUSY and drop m_req.
  - While m_rdy = 0: hold ISSUE, m_req and operands stable.
- BUSY:
  - m_req = 0.
  - On an edge with m_done = 1: ab_out <= m_ab; done_vec[W] = 1 for one cycle; pointer <= (W+1) mod NREQ; go to IDLE.
- Latency and throughput (multiplier latency L cycles after accept):
  - Grant appears 1 cycle after the request is seen.
  - Result appears 1 cycle after m_done.
  - Back-to-back grants are at least 3 + L cycles apart.
- Requester rules:
  - Hold req and operands until the gnt pulse.
  - req_vec changes after the grant do not affect the transaction in flight.
  - req still high after done re-requests.
  - Dropping req before grant withdraws the request without error.
- Fairness: a continuously requesting requester is granted within NREQ transactions.
- Simultaneous events: m_done and new requests in the same cycle are handled by the sequencing above; the new request is seen in IDLE on the following cycle.
- Other invariants:
  - m_done outside BUSY is ignored.
  - gnt_vec and done_vec are never multi-hot.
  - Outputs are registered except busy, which is decoded from state.

Optional Feature:
- MULT_ARB_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to ISSUE and counts in ISSUE and BUSY.
  - On reaching TIMEOUT without m_done: done_vec[W] pulses with ab_out = 0 and err_out = 1 for that cycle; the pointer advances; FSM returns to IDLE.
  - Any later stray m_done is ignored.
- Undefined: no counter; err_out is tied 0; the FSM waits indefinitely.

Test Plan:
- Reset: hold rst=1 for 3 cycles with req_vec=4'b1111 -> all outputs 0, no gnt; first gnt after release goes to req 0.
- Single request: req_vec=4'b0100, a=31, b=31 -> gnt_vec=4'b0100 one cycle later; m_a=31, m_b=31; after m_done, done_vec=4'b0100 and ab_out=961 for exactly one cycle.
- Fairness: req_vec=4'b1111 held for 8 transactions, a_i=i+1, b_i=3 -> grant order 0,1,2,3,0,1,2,3; results 3,6,9,12 repeated.
- Stall: requester 1 with a=7, b=5 while m_rdy=0 for 4 cycles in ISSUE -> m_req and m_a/m_b stable throughout; accepted on first m_rdy=1; done_vec[1] with ab_out=35.
- Mid-operation reset: rst=1 while in BUSY -> no done pulse; pointer 0; next req_vec=4'b0010 grants requester 1 normally.
- With MULT_ARB_TIMEOUT_EN and TIMEOUT=10, m_done never asserted -> done_vec[W] and err_out=1 with ab_out=0 at cycle 10 after ISSUE entry; a subsequent m_done is ignored.

Source files
------------

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter and sequencer sharing one multiplier
// between NREQ requesters. It latches the winner's operands, drives the
// multiplier req/rdy/done handshake and returns the product with a
// one-cycle done pulse to the winner.
// Optional watchdog: define MULT_ARB_TIMEOUT_EN to abort a transaction that
// spends TIMEOUT cycles in ISSUE/BUSY without m_done. The aborted transaction
// returns ab_out=0 with err_out=1.
module mult_arbiter #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_vec,
  input  logic [NREQ*WIDTH-1:0] a_vec,
  input  logic [NREQ*WIDTH-1:0] b_vec,
  output logic [NREQ-1:0]       gnt_vec,
  output logic [NREQ-1:0]       done_vec,
  output logic [2*WIDTH-1:0]    ab_out,
  output logic                  err_out,
  output logic                  busy,
  output logic                  m_req,
  input  logic                  m_rdy,
  output logic [WIDTH-1:0]      m_a,
  output logic [WIDTH-1:0]      m_b,
  input  logic                  m_done,
  input  logic [2*WIDTH-1:0]    m_ab
);

  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mult_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t              state, state_nx;
  logic [IW-1:0]       ptr, ptr_nx;
  logic [IW-1:0]       win, win_nx;
  logic [IW-1:0]       pick;
  logic                found;
  logic                grant_go;
  logic                done_ok;
  logic                timeout_hit;
  logic                timeout_fin;
  logic                finish;
  logic [NREQ-1:0]     gnt_nx, done_nx;
  logic [2*WIDTH-1:0]  ab_nx;
  logic [WIDTH-1:0]    m_a_nx, m_b_nx;
  logic                m_req_nx;

  // Round-robin search: first requesting index at or above ptr, wrapping.
  always_comb begin
    logic [IW-1:0] idx;
    pick  = ptr;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IW'((32'(ptr) + k) % NREQ);
      if (!found && req_vec[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign grant_go    = (state == IDLE) && found && m_rdy;
  assign done_ok     = (state == BUSY) && m_done;
  assign timeout_fin = (state != IDLE) && timeout_hit && !done_ok;
  assign finish      = done_ok || timeout_fin;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt;
  logic          err_r;

  assign timeout_hit = (wd_cnt == CW'(TIMEOUT - 1));
  assign err_out     = err_r;

  // Watchdog: held at zero in IDLE, so it starts from zero on ISSUE entry.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      wd_cnt <= '0;
    end else if (!timeout_hit) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Error flag accompanies the done pulse of an aborted transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= timeout_fin;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_out     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant_go) state_nx = ISSUE;
      ISSUE: begin
        if (timeout_fin)  state_nx = IDLE;
        else if (m_rdy)   state_nx = BUSY;
      end
      BUSY:    if (finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values for the registered outputs and the winner/pointer.
  // m_req is registered from the next state so it is high exactly in ISSUE.
  always_comb begin
    gnt_nx   = '0;
    done_nx  = '0;
    ab_nx    = ab_out;
    m_a_nx   = m_a;
    m_b_nx   = m_b;
    win_nx   = win;
    ptr_nx   = ptr;
    m_req_nx = (state_nx == ISSUE);
    if (grant_go) begin
      win_nx = pick;
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (pick == IW'(k)) begin
          gnt_nx[k] = 1'b1;
          m_a_nx    = a_vec[k*WIDTH +: WIDTH];
          m_b_nx    = b_vec[k*WIDTH +: WIDTH];
        end
      end
    end
    if (finish) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        done_nx[k] = (win == IW'(k));
      end
      ab_nx  = done_ok ? m_ab : '0;
      ptr_nx = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_vec  <= '0;
      done_vec <= '0;
      ab_out   <= '0;
      m_req    <= 1'b0;
      m_a      <= '0;
      m_b      <= '0;
      win      <= '0;
      ptr      <= '0;
    end else begin
      gnt_vec  <= gnt_nx;
      done_vec <= done_nx;
      ab_out   <= ab_nx;
      m_req    <= m_req_nx;
      m_a      <= m_a_nx;
      m_b      <= m_b_nx;
      win      <= win_nx;
      ptr      <= ptr_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule
